// File: rtl/reg_file_pkg.sv
// Shared CPU register-file definitions: widths, the hard-wired zero register and
// instruction field positions used by decode and the register file.
package reg_file_pkg;

  localparam int unsigned CPU_DATA_W     = 32;
  localparam int unsigned CPU_REG_ADDR_W = 5;
  localparam int unsigned CPU_NUM_REGS   = 2 ** CPU_REG_ADDR_W;

  localparam logic [CPU_REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

  typedef logic [CPU_DATA_W-1:0]     word_t;
  typedef logic [CPU_REG_ADDR_W-1:0] reg_addr_t;

  function automatic reg_addr_t get_rs(input word_t instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic reg_addr_t get_rt(input word_t instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic reg_addr_t get_rd(input word_t instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic is_reg_zero(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// Combinational register-file read port; address 0 is forced to zero because
// register 0 has no storage.
module reg_file_read_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [1:(2**ADDR_W)-1],
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit CPU register file: one synchronous write port, three combinational
// read ports (rs, rt, debug), register 0 hard-wired to zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned       DATA_W    = CPU_DATA_W,
  parameter int unsigned       ADDR_W    = CPU_REG_ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic              wr_en;

  assign wr_en = (reg_write == 1'b1) && (rd_addr != '0);

  // No read bypass: reads see the old value until the edge, which keeps the
  // ALU -> wr_data path free of a combinational loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      regs_q[rd_addr] <= wr_data;
    end
  end

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs_port (
    .addr (rs_addr),
    .regs (regs_q),
    .data (rs_data)
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rt_port (
    .addr (rt_addr),
    .regs (regs_q),
    .data (rt_data)
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dbg_port (
    .addr (dbg_addr),
    .regs (regs_q),
    .data (dbg_data)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(reg_write))
      else $error("reg_file: reg_write is X/Z at clock edge");
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file against an array-based reference model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, rd_addr, dbg_addr;
  logic [31:0] wr_data;
  logic        reg_write;
  logic [31:0] rs_data, rt_data, dbg_data;

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .wr_data   (wr_data),
    .reg_write (reg_write),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] dbg;
  } exp_t;

  exp_t        exp_q [$];
  string       name_q [$];
  event        chk_ev;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [32];

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // Expected values come from the model; the monitor compares them a moment later.
  task automatic check(input string name);
    exp_t e;
    e.rs  = ref_read(rs_addr);
    e.rt  = ref_read(rt_addr);
    e.dbg = ref_read(dbg_addr);
    exp_q.push_back(e);
    name_q.push_back(name);
    -> chk_ev;
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // Clock edge, then apply the write the model expects the DUT to have taken.
  task automatic edge_and_commit();
    @(posedge clk);
    #1;
    if (rst_n && reg_write && rd_addr != 5'd0) model[rd_addr] = wr_data;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg,
                       input logic [4:0] rd, input logic [31:0] d, input logic we);
    rs_addr = rs; rt_addr = rt; dbg_addr = dbg; rd_addr = rd; wr_data = d; reg_write = we;
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(chk_ev);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL monitor: got output with empty scoreboard, required an entry");
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rs_data !== e.rs) begin
          miscompares++;
          $display("FAIL %s rs_data: got %h required %h", n, rs_data, e.rs);
        end
        vectors++;
        if (rt_data !== e.rt) begin
          miscompares++;
          $display("FAIL %s rt_data: got %h required %h", n, rt_data, e.rt);
        end
        vectors++;
        if (dbg_data !== e.dbg) begin
          miscompares++;
          $display("FAIL %s dbg_data: got %h required %h", n, dbg_data, e.dbg);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    drive(5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #12;
    check("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reg 5 loaded, then reset asserted between edges must clear it at once.
    drive(5'd5, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 1'b1);
    edge_and_commit();
    drive(5'd5, 5'd5, 5'd5, 5'd0, 32'd0, 1'b0);
    check("reg5_loaded");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_no_clk");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two writes then read both.
    drive(5'd0, 5'd0, 5'd0, 5'd1, 32'h1, 1'b1);
    edge_and_commit();
    drive(5'd0, 5'd0, 5'd0, 5'd2, 32'h2, 1'b1);
    edge_and_commit();
    drive(5'd1, 5'd2, 5'd2, 5'd0, 32'd0, 1'b0);
    check("rs1_rt2");

    // Write to reg 0 discarded.
    drive(5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    edge_and_commit();
    drive(5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    check("reg0_write_ignored");

    // Read-during-write returns old value until the edge.
    drive(5'd3, 5'd3, 5'd3, 5'd3, 32'd3, 1'b1);
    edge_and_commit();
    drive(5'd3, 5'd3, 5'd3, 5'd3, 32'd4, 1'b1);
    check("rdw_before_edge");
    edge_and_commit();
    reg_write = 1'b0;
    check("rdw_after_edge");

    // Disabled write leaves reg 7 untouched.
    drive(5'd7, 5'd7, 5'd7, 5'd7, 32'h12345678, 1'b0);
    edge_and_commit();
    check("write_disabled");

    // Reset pulse straddling a write edge: reset wins.
    drive(5'd9, 5'd9, 5'd9, 5'd9, 32'hA5A5A5A5, 1'b1);
    edge_and_commit();
    drive(5'd9, 5'd9, 5'd9, 5'd9, 32'h0BADF00D, 1'b1);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check("reset_wins_over_write");
    edge_and_commit();
    check("write_after_reset");

    // Randomised traffic, small address window for frequent collisions.
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ((i % 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
            $urandom, 1'($urandom_range(0, 3) != 0));
      if ((i % 7) == 0) rt_addr = rs_addr;
      if ((i % 5) == 0) rs_addr = rd_addr;
      check("random");
      edge_and_commit();
    end

    reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a); dbg_addr = 5'(a);
      check("final_sweep");
    end

    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
